dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the core load/store port and the read-only debug port (the path that serves the addr_i/data_o inspection interface).
- Sits between the datapath/debug logic and the data memory.
- Sequences one outstanding transaction at a time.
- Applies fixed core priority with a starvation bound for debug, and rejects misaligned or out-of-range accesses without touching memory.

Parameters:
XLEN, 32, data/address width
DEPTH_WORDS, 1024, memory depth in words; word index >= DEPTH_WORDS is out of range
MAX_CORE_BURST, 4, consecutive core grants allowed while debug waits (>=1)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset; asynchronous, active-low
core_req_i  in  1  core request; held with stable fields until core_gnt_o
core_we_i  in  1  core write enable
core_addr_i  in  XLEN  core byte address
core_wdata_i  in  XLEN  core write data
core_gnt_o  out  1  core request accepted this cycle
core_rvalid_o  out  1  core response valid (one cycle)
core_rdata_o  out  XLEN  core read data (0 on writes/errors)
core_err_o  out  1  core response is an error
dbg_req_i  in  1  debug read request; held until dbg_gnt_o
dbg_addr_i  in  XLEN  debug byte address
dbg_gnt_o  out  1  debug request accepted
dbg_rvalid_o  out  1  debug response valid
dbg_rdata_o  out  XLEN  debug read data
dbg_err_o  out  1  debug response is an error
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_addr_o  out  XLEN  memory byte address
mem_wdata_o  out  XLEN  memory write data
mem_gnt_i  in  1  memory accepts request
mem_rvalid_i  in  1  memory completion (reads and writes)
mem_rdata_i  in  XLEN  memory read data

Behaviour:
- Reset (rstn_i low, async): state IDLE, burst_cnt=0, owner cleared. All rvalid/err/gnt/mem_req outputs 0; rdata outputs 0. mem_we/addr/wdata are 0 when mem_req_o=0.
- States: IDLE, WAIT_MEM, ERR_RSP.
- IDLE, winner selection:
  - Only one request -> that requester wins.
  - Both request -> core wins, unless burst_cnt==MAX_CORE_BURST, then debug wins.
- IDLE, legal winner (addr[1:0]==0 and addr>>2 < DEPTH_WORDS):
  - mem_req_o=1 combinationally, carrying the winner's fields; debug forces mem_we_o=0 and mem_wdata_o=0.
  - Winner's gnt = mem_gnt_i.
  - On gnt: record owner, go to WAIT_MEM. Without gnt: stay IDLE and re-arbitrate next cycle.
- IDLE, illegal winner:
  - mem_req_o=0; winner's gnt=1 that cycle; record owner; go to ERR_RSP.
- WAIT_MEM:
  - No grants; mem_req_o=0.
  - On mem_rvalid_i: capture mem_rdata_i (or 0 if the owner wrote) and go to IDLE.
  - Next cycle: owner rvalid=1 for exactly one cycle, err=0.
- ERR_RSP: next cycle owner rvalid=1, err=1, rdata=0; go to IDLE.
- Response outputs are registered: response appears 1 cycle after mem_rvalid_i, or 1 cycle after an error grant.
- A new grant may occur in the same cycle a response is presented.
- Minimum read latency (gnt to rvalid): 2 cycles with a 1-cycle memory.
- Throughput: max one grant per 2 cycles.
- burst_cnt:
  - Core grant while dbg_req_i=1: burst_cnt+1, saturating at MAX_CORE_BURST.
  - Core grant while dbg_req_i=0: burst_cnt=0.
  - Debug grant: burst_cnt=0.
  - Error grants count as grants.
- mem_rvalid_i outside WAIT_MEM is ignored, including a stale completion after reset.
- Requester dropping req before gnt: protocol violation. No requirement beyond not corrupting state; the request is simply not granted.
- Reset mid-transaction: outstanding response is discarded; no rvalid issued.
- Only the owner's rvalid/rdata/err change; the non-owner's outputs stay 0.

Test Plan:
- Core write 0x0000_0010 data 0xDEAD_BEEF, then core read 0x10 (1-cycle memory) -> gnt, mem_we_o=1 then 0; write rvalid with rdata 0; read rvalid 2 cycles after gnt with rdata 0xDEAD_BEEF, err 0.
- Debug read 0x10 while core idle -> dbg_gnt_o, mem_we_o=0, dbg_rvalid_o with 0xDEAD_BEEF; core_rvalid_o stays 0.
- Core and debug requesting continuously, MAX_CORE_BURST=4 -> grant order C,C,C,C,D,C,C,C,C,D; debug waits no more than 4 core grants.
- Core read 0x0000_0012 (misaligned) and debug read 0x0000_1000 (word 1024, out of range) -> no mem_req_o; each gets rvalid with err=1, rdata=0 one cycle after gnt.
- mem_gnt_i held low 3 cycles with core_req_i high -> core_gnt_o low, mem_req_o stays high with stable fields; grant on cycle 4.
- Assert rstn_i low in WAIT_MEM, then mem_rvalid_i arrives after release -> no rvalid on either port; state IDLE; next request serviced normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the core load/store port and
// the read-only debug port. One transaction is outstanding at a time.
module dmem_arbiter #(
  parameter int XLEN           = 32,
  parameter int DEPTH_WORDS    = 1024,
  parameter int MAX_CORE_BURST = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  output logic            core_gnt_o,
  output logic            core_rvalid_o,
  output logic [XLEN-1:0] core_rdata_o,
  output logic            core_err_o,
  input  logic            dbg_req_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            dbg_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int              CW        = $clog2(MAX_CORE_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_CORE_BURST);
  localparam logic [XLEN-1:0] DEPTH_LIM = XLEN'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, ERR_RSP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            owner_dbg_q, owner_dbg_d;
  logic            owner_we_q, owner_we_d;
  logic            core_rvalid_q, core_rvalid_d;
  logic            core_err_q, core_err_d;
  logic [XLEN-1:0] core_rdata_q, core_rdata_d;
  logic            dbg_rvalid_q, dbg_rvalid_d;
  logic            dbg_err_q, dbg_err_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;

  logic            is_idle;
  logic            any_req;
  logic            sel_dbg;
  logic [XLEN-1:0] win_addr;
  logic            win_legal;
  logic            grant;
  logic [XLEN-1:0] rsp_data;

  // Gating with rstn_i keeps grants and memory requests low while reset is held.
  assign is_idle   = (state_q == IDLE) && rstn_i;
  assign any_req   = core_req_i || dbg_req_i;
  assign sel_dbg   = dbg_req_i && (!core_req_i || (burst_cnt_q == BURST_MAX));
  assign win_addr  = sel_dbg ? dbg_addr_i : core_addr_i;
  assign win_legal = (win_addr[1:0] == 2'b00) && ((win_addr >> 2) < DEPTH_LIM);
  // Illegal accesses are accepted locally without a memory handshake.
  assign grant     = is_idle && any_req && (win_legal ? mem_gnt_i : 1'b1);

  assign mem_req_o   = is_idle && any_req && win_legal;
  assign mem_we_o    = mem_req_o && !sel_dbg && core_we_i;
  assign mem_addr_o  = mem_req_o ? win_addr : '0;
  assign mem_wdata_o = (mem_req_o && !sel_dbg) ? core_wdata_i : '0;

  assign core_gnt_o = grant && !sel_dbg;
  assign dbg_gnt_o  = grant && sel_dbg;

  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign core_err_o    = core_err_q;
  assign dbg_rvalid_o  = dbg_rvalid_q;
  assign dbg_rdata_o   = dbg_rdata_q;
  assign dbg_err_o     = dbg_err_q;

  assign rsp_data = owner_we_q ? '0 : mem_rdata_i;

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    owner_dbg_d   = owner_dbg_q;
    owner_we_d    = owner_we_q;
    core_rvalid_d = 1'b0;
    core_err_d    = 1'b0;
    core_rdata_d  = '0;
    dbg_rvalid_d  = 1'b0;
    dbg_err_d     = 1'b0;
    dbg_rdata_d   = '0;

    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_dbg_d = sel_dbg;
          owner_we_d  = !sel_dbg && core_we_i;
          if (sel_dbg || !dbg_req_i) begin
            burst_cnt_d = '0;
          end else if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
          if (win_legal) begin
            state_d = WAIT_MEM;
          end else begin
            // Error response goes out next cycle while ERR_RSP holds off new grants.
            state_d = ERR_RSP;
            if (sel_dbg) begin
              dbg_rvalid_d = 1'b1;
              dbg_err_d    = 1'b1;
            end else begin
              core_rvalid_d = 1'b1;
              core_err_d    = 1'b1;
            end
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_dbg_q) begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = rsp_data;
          end else begin
            core_rvalid_d = 1'b1;
            core_rdata_d  = rsp_data;
          end
        end
      end
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      burst_cnt_q   <= '0;
      owner_dbg_q   <= 1'b0;
      owner_we_q    <= 1'b0;
      core_rvalid_q <= 1'b0;
      core_err_q    <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rvalid_q  <= 1'b0;
      dbg_err_q     <= 1'b0;
      dbg_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      owner_dbg_q   <= owner_dbg_d;
      owner_we_q    <= owner_we_d;
      core_rvalid_q <= core_rvalid_d;
      core_err_q    <= core_err_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      dbg_err_q     <= dbg_err_d;
      dbg_rdata_q   <= dbg_rdata_d;
    end
  end

endmodule
